// File: rtl/mac_dot_ctrl.sv
// KLEN-tap Q4.12 x Q2.14 dot-product sequencer around a single multiplier.
// Full-precision Q6.26 accumulation; the result is rounded half-up and saturated to Q4.12.
module qmult (
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  output logic signed [31:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module mac_dot_ctrl #(
  parameter int KLEN  = 3,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_act,
  input  logic [15:0] s_wgt,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sat,
  output logic        o_busy
);
  localparam int CNT_W = $clog2(KLEN + 1);
  localparam logic signed [ACC_W-1:0] L_HALF = ACC_W'(8192);
  localparam logic signed [ACC_W-1:0] L_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] L_MIN  = ACC_W'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  state_t                    r_state, w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [31:0]        w_prod;
  logic signed [ACC_W-1:0]   w_acc_nxt, w_r;
  logic                      w_hs, w_last, w_clr;

  qmult u_qmult (.i_a(s_act), .i_b(s_wgt), .o_p(w_prod));

  assign s_ready   = (r_state == S_ACC);
  assign m_valid   = (r_state == S_OUT);
  assign o_busy    = (r_state != S_IDLE);
  assign w_hs      = s_valid & s_ready;
  assign w_last    = (r_cnt == CNT_W'(KLEN - 1));
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);
  // The result is formed from the sum including the final tap so it can be registered on entry to OUT.
  assign w_r       = (w_acc_nxt + L_HALF) >>> 14;

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_ACC;
        w_clr       = 1'b1;
      end
      S_ACC: if (w_hs && w_last) w_state_nxt = S_OUT;
      S_OUT: if (m_ready) begin
        if (i_start) begin
          w_state_nxt = S_ACC;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      m_data  <= '0;
      m_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_hs) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_hs && w_last) begin
        if (w_r > L_MAX) begin
          m_data <= 16'h7FFF;
          m_sat  <= 1'b1;
        end else if (w_r < L_MIN) begin
          m_data <= 16'h8000;
          m_sat  <= 1'b1;
        end else begin
          m_data <= w_r[15:0];
          m_sat  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Randomized bench for mac_dot_ctrl against a plain-arithmetic dot-product model.
module tb_mac_dot_ctrl;
  localparam int KLEN = 3;

  logic        clk, rst_n, i_start, s_valid, s_ready, m_valid, m_ready, m_sat, o_busy;
  logic [15:0] s_act, s_wgt, m_data;
  int          n_chk, n_pass;

  mac_dot_ctrl #(.KLEN(KLEN), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_act(s_act), .s_wgt(s_wgt), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_sat(m_sat), .o_busy(o_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model(input logic [15:0] a[KLEN], input logic [15:0] w[KLEN],
                                output logic [15:0] d, output logic s);
    longint sum, r;
    sum = 0;
    for (int k = 0; k < KLEN; k++)
      sum += longint'($signed(a[k])) * longint'($signed(w[k]));
    r = (sum + 64'sd8192) >>> 14;
    if (r > 32767)       begin d = 16'h7FFF; s = 1'b1; end
    else if (r < -32768) begin d = 16'h8000; s = 1'b1; end
    else                 begin d = 16'(r);   s = 1'b0; end
  endfunction

  // Called at posedge+1 in IDLE; a simultaneous pair must not be taken.
  task automatic start_dot();
    i_start = 1'b1; s_valid = 1'b1; s_act = 16'h7FFF; s_wgt = 16'h7FFF;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 0);
    @(posedge clk); #1;
    i_start = 1'b0; s_valid = 1'b0;
  endtask

  // Feeds KLEN pairs with optional gaps, then holds m_ready low for mhold cycles.
  task automatic feed(input logic [15:0] a[KLEN], input logic [15:0] w[KLEN],
                      input int maxgap, input int mhold, input logic nxt);
    logic [15:0] ed, held;
    logic        es;
    model(a, w, ed, es);
    for (int k = 0; k < KLEN; k++) begin
      int g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      for (int j = 0; j < g; j++) begin
        s_valid = 1'b0; s_act = 16'($urandom); s_wgt = 16'($urandom);
        i_start = 1'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1; s_act = a[k]; s_wgt = w[k]; i_start = 1'($urandom);
      @(negedge clk);
      chk("acc_s_ready", s_ready, 1);
      chk("acc_m_valid", m_valid, 0);
      @(posedge clk); #1;
    end
    // Junk pair offered during OUT must be ignored.
    s_valid = 1'b1; s_act = 16'h7FFF; s_wgt = 16'h7FFF; i_start = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    chk("out_m_valid", m_valid, 1);
    chk("out_s_ready", s_ready, 0);
    chk("out_m_data", m_data, ed);
    chk("out_m_sat", m_sat, es);
    held = m_data;
    for (int j = 0; j < mhold; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_data", m_data, held);
    end
    @(posedge clk); #1;
    m_ready = 1'b1; i_start = nxt;
    @(posedge clk); #1;
    m_ready = 1'b0; i_start = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("post_m_valid", m_valid, 0);
    chk("post_busy", o_busy, nxt);
    chk("post_s_ready", s_ready, nxt);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outs();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_busy", o_busy, 0);
  endtask

  logic [15:0] a[KLEN], w[KLEN];
  logic        b2b, nb;

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; i_start = 1'b0; s_valid = 1'b0; s_act = '0; s_wgt = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: unity, signed mix, rounding up, tie toward +inf, saturation both ways.
    a = '{16'h1000, 16'h1000, 16'h1000}; w = '{16'h4000, 16'h4000, 16'h4000};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    a = '{16'hF000, 16'h1000, 16'hF000}; w = '{16'h2000, 16'h2000, 16'h4000};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    a = '{16'h0001, 16'h0000, 16'h0000}; w = '{16'h2000, 16'h0000, 16'h0000};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    a = '{16'hFFFF, 16'h0000, 16'h0000}; w = '{16'h2000, 16'h0000, 16'h0000};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    a = '{16'h7FFF, 16'h7FFF, 16'h7FFF}; w = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    a = '{16'h8000, 16'h8000, 16'h8000}; w = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    start_dot(); feed(a, w, 0, 0, 1'b0);
    // Gaps, 5-cycle backpressure, then a back-to-back dot product.
    a = '{16'h0800, 16'hF800, 16'h2000}; w = '{16'h4000, 16'h1000, 16'hC000};
    start_dot(); feed(a, w, 1, 5, 1'b1);
    a = '{16'h0100, 16'h0200, 16'h0300}; w = '{16'h4000, 16'h4000, 16'h4000};
    feed(a, w, 0, 0, 1'b0);

    // Randomized: full-range or small operands, random gaps, holds and chaining.
    b2b = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < KLEN; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          a[k] = 16'($urandom); w[k] = 16'($urandom);
        end else begin
          a[k] = 16'($signed(12'($urandom))); w[k] = 16'($signed(15'($urandom)));
        end
      end
      nb = 1'($urandom);
      if (!b2b) start_dot();
      feed(a, w, 2, $urandom_range(3, 0), nb);
      b2b = nb;
    end
    if (b2b) begin
      a = '{16'h0, 16'h0, 16'h0}; w = '{16'h0, 16'h0, 16'h0};
      feed(a, w, 0, 0, 1'b0);
    end

    // Reset after 2 of 3 pairs, then a fresh dot product sees only new pairs.
    start_dot();
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_act = 16'h4000; s_wgt = 16'h4000;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = '{16'h1000, 16'h0000, 16'hF000}; w = '{16'h4000, 16'h0000, 16'h2000};
    start_dot(); feed(a, w, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
